// File: rtl/bcd_7seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module : bcd_disp_pkg
// Brief  : Active-low segment glyphs and width helper for the BCD scan display
// Rev    : 1.0
// ============================================================================
package bcd_disp_pkg;

    // Bit order {g,f,e,d,c,b,a}, 0 = segment lit
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // $clog2 clamped to at least one bit so single-entry counters stay legal
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : bcd_disp_pkg
`default_nettype wire

// File: rtl/bcd_7seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module : bcd_7seg_scan_if
// Brief  : valid/ready handshake carrying packed BCD digits to the scanner
// Rev    : 1.0
// ============================================================================
interface bcd_7seg_scan_if #(
    parameter int NUM_DIGITS = 2
) ();
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    bcd_valid;
    logic                    bcd_ready;

    modport master (output bcd_in, output bcd_valid, input  bcd_ready);
    modport slave  (input  bcd_in, input  bcd_valid, output bcd_ready);
endinterface : bcd_7seg_scan_if
`default_nettype wire

// File: rtl/bcd_7seg_scan_decode.sv
`default_nettype none
// ============================================================================
// Module : bcd7seg_decode
// Brief  : Combinational nibble to active-low 7-segment glyph, dash for A-F
// Rev    : 1.0
// ============================================================================
module bcd7seg_decode
    import bcd_disp_pkg::*;
(
    input  wire logic [3:0] i_nibble,
    output logic      [6:0] o_seg_n
);
    always_comb begin
        o_seg_n = SEG_DASH;
        case (i_nibble)
            4'd0:    o_seg_n = SEG_0;
            4'd1:    o_seg_n = SEG_1;
            4'd2:    o_seg_n = SEG_2;
            4'd3:    o_seg_n = SEG_3;
            4'd4:    o_seg_n = SEG_4;
            4'd5:    o_seg_n = SEG_5;
            4'd6:    o_seg_n = SEG_6;
            4'd7:    o_seg_n = SEG_7;
            4'd8:    o_seg_n = SEG_8;
            4'd9:    o_seg_n = SEG_9;
            default: o_seg_n = SEG_DASH;
        endcase
    end
endmodule : bcd7seg_decode
`default_nettype wire

// File: rtl/bcd_7seg_scan.sv
`default_nettype none
// ============================================================================
// Module : bcd_7seg_scan
// Brief  : Double-buffered, time-multiplexed common-anode 7-segment scanner
// Rev    : 1.0
// ============================================================================
module bcd_7seg_scan
    import bcd_disp_pkg::*;
#(
    parameter int                    NUM_DIGITS  = 2,
    parameter int                    REFRESH_DIV = 1000,
    parameter logic [NUM_DIGITS-1:0] DP_MASK     = '0
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    bcd_7seg_scan_if.slave             bus,
    input  wire logic                  lz_blank,
    output logic      [NUM_DIGITS-1:0] an_n,
    output logic      [6:0]            seg_n,
    output logic                       dp_n
);
    localparam int IDX_W = idx_w(NUM_DIGITS);
    localparam int PRE_W = idx_w(REFRESH_DIV);
    localparam int DW    = 4 * NUM_DIGITS;

    logic [PRE_W-1:0]      r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [DW-1:0]         r_pending;
    logic [DW-1:0]         r_display;
    logic                  r_pend_full;

    logic                  w_slot_end;
    logic                  w_frame;
    logic                  w_accept;
    logic [3:0]            w_nib;
    logic [6:0]            w_seg_dec;
    logic [NUM_DIGITS-1:0] w_upper_zero;
    logic                  w_run;
    logic                  w_blank;

    assign w_slot_end    = (r_presc == PRE_W'(REFRESH_DIV - 1));
    assign w_frame       = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_accept      = bus.bcd_valid && !r_pend_full;
    assign bus.bcd_ready = ~r_pend_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_pending   <= '0;
            r_display   <= '0;
            r_pend_full <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_presc <= '0;
                r_idx   <= w_frame ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
            // Accept only happens while empty, so it can never race the frame swap
            if (w_accept) begin
                r_pending   <= bus.bcd_in;
                r_pend_full <= 1'b1;
            end else if (w_frame && r_pend_full) begin
                r_display   <= r_pending;
                r_pend_full <= 1'b0;
            end
        end
    end

    assign w_nib = r_display[4*r_idx +: 4];

    bcd7seg_decode u_decode (
        .i_nibble (w_nib),
        .o_seg_n  (w_seg_dec)
    );

    // w_upper_zero[k] = nibbles k..NUM_DIGITS-1 are all zero
    always_comb begin
        w_upper_zero = '0;
        w_run        = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_run           = w_run & (r_display[4*k +: 4] == 4'h0);
            w_upper_zero[k] = w_run;
        end
    end

    assign w_blank = lz_blank && (r_idx != '0) && w_upper_zero[r_idx];

    // Slot's first cycle is dead time to stop ghosting between digits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_n  <= '1;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else if (r_presc == '0) begin
            an_n  <= '1;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= ~(NUM_DIGITS'(1) << r_idx);
            seg_n <= w_blank ? SEG_BLANK : w_seg_dec;
            dp_n  <= ~DP_MASK[r_idx];
        end
    end

endmodule : bcd_7seg_scan
`default_nettype wire

// File: tb/tb_bcd_7seg_scan.sv
`default_nettype none
// ============================================================================
// Module : tb_bcd_7seg_scan
// Brief  : Randomized and directed self-checking bench with a cycle-time model
// Rev    : 1.0
// ============================================================================
module tb_bcd_7seg_scan;
    localparam int          ND    = 2;
    localparam int          RD    = 4;
    localparam logic [1:0]  DPM   = 2'b10;
    localparam int          FRAME = ND * RD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lz_blank = 1'b0;
    logic [1:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;

    int checks = 0;
    int errors = 0;

    bcd_7seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    bcd_7seg_scan #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .DP_MASK     (DPM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .lz_blank (lz_blank),
        .an_n     (an_n),
        .seg_n    (seg_n),
        .dp_n     (dp_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (n < 4'd10) ? tbl[n] : 7'b0111111;
    endfunction

    // Model: cycles since reset determine slot and digit; display swaps at frame end
    int         m_tick = 0;
    logic       m_full = 1'b0;
    logic [7:0] m_pend = '0;
    logic [7:0] m_disp = '0;
    logic [1:0] exp_an = 2'b11;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tick = 0; m_full = 1'b0; m_pend = '0; m_disp = '0;
            exp_an = 2'b11; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            int pos, dig;
            logic [7:0] upper;
            pos = m_tick % RD;
            dig = (m_tick / RD) % ND;
            if (pos == 0) begin
                exp_an = 2'b11; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                upper   = m_disp >> (4 * dig);
                exp_an  = 2'b11 & ~(2'b01 << dig);
                exp_seg = (lz_blank && dig > 0 && upper == 8'h00) ? 7'h7F : glyph(upper[3:0]);
                exp_dp  = ~DPM[dig];
            end
            if (bus.bcd_valid && !m_full) begin
                m_pend = bus.bcd_in; m_full = 1'b1;
            end else if ((m_tick % FRAME) == FRAME - 1 && m_full) begin
                m_disp = m_pend; m_full = 1'b0;
            end
            m_tick++;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (an_n !== exp_an || seg_n !== exp_seg || bus.bcd_ready !== !m_full ||
            (exp_an != 2'b11 && dp_n !== exp_dp)) begin
            errors++;
            $display("FAIL model t=%0t an_n=%b/%b seg_n=%b/%b dp_n=%b/%b ready=%b/%b",
                     $time, an_n, exp_an, seg_n, exp_seg, dp_n, exp_dp, bus.bcd_ready, !m_full);
        end
    end

    task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic wait_an(input logic [1:0] target);
        int n = 0;
        do begin @(negedge clk); n++; end while (an_n !== target && n < 100);
        if (an_n !== target) check_lit("wait_an timeout", {6'd0, an_n}, {6'd0, target});
    endtask

    task automatic send(input logic [7:0] v);
        int n = 0;
        bus.bcd_valid = 1'b1;
        bus.bcd_in    = v;
        while (!bus.bcd_ready && n < 100) begin @(negedge clk); n++; end
        if (!bus.bcd_ready) check_lit("send timeout", 8'd0, 8'd1);
        @(negedge clk);
        bus.bcd_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (2 * FRAME + 2) @(negedge clk);
    endtask

    initial begin
        int n;
        bus.bcd_valid = 1'b0;
        bus.bcd_in    = '0;
        repeat (10) begin
            @(negedge clk);
            check_lit("reset an_n",  {6'd0, an_n}, 8'h03);
            check_lit("reset seg_n", {1'b0, seg_n}, 8'h7F);
            check_lit("reset dp_n/ready", {6'd0, dp_n, bus.bcd_ready}, 8'h03);
        end
        rst = 1'b0;

        // 42: glyphs, decimal point and dead time
        send(8'h42);
        settle();
        wait_an(2'b10);
        check_lit("d0 of 42", {dp_n, seg_n}, {1'b1, 7'b0100100});
        wait_an(2'b01);
        check_lit("d1 of 42", {dp_n, seg_n}, {1'b0, 7'b0011001});
        n = 0;
        while (an_n == 2'b01 && n < 20) begin @(negedge clk); n++; end
        check_lit("dead time", {6'd0, an_n}, 8'h03);

        // Leading-zero blanking
        lz_blank = 1'b1;
        send(8'h07);
        settle();
        wait_an(2'b01);
        check_lit("lz blank d1", {1'b0, seg_n}, 8'h7F);
        wait_an(2'b10);
        check_lit("d0 of 07", {1'b0, seg_n}, {1'b0, 7'b1111000});
        lz_blank = 1'b0;
        wait_an(2'b01);
        check_lit("lz off d1", {1'b0, seg_n}, {1'b0, 7'b1000000});

        // Back-to-back words with valid held
        bus.bcd_valid = 1'b1;
        bus.bcd_in    = 8'h12;
        n = 0;
        while (!bus.bcd_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.bcd_in = 8'h34;
        check_lit("stall ready", {7'd0, bus.bcd_ready}, 8'h00);
        n = 0;
        while (!bus.bcd_ready && n < 100) begin @(negedge clk); n++; end
        check_lit("stall released", {7'd0, bus.bcd_ready}, 8'h01);
        @(negedge clk);
        bus.bcd_valid = 1'b0;
        wait_an(2'b10);
        check_lit("frame 12 d0", {1'b0, seg_n}, {1'b0, 7'b0100100});
        wait_an(2'b01);
        check_lit("frame 12 d1", {1'b0, seg_n}, {1'b0, 7'b1111001});
        settle();
        wait_an(2'b10);
        check_lit("frame 34 d0", {1'b0, seg_n}, {1'b0, 7'b0011001});
        wait_an(2'b01);
        check_lit("frame 34 d1", {1'b0, seg_n}, {1'b0, 7'b0110000});

        // Non-BCD nibble shows a dash
        send(8'hC5);
        settle();
        wait_an(2'b01);
        check_lit("dash d1", {1'b0, seg_n}, {1'b0, 7'b0111111});
        wait_an(2'b10);
        check_lit("C5 d0", {1'b0, seg_n}, {1'b0, 7'b0010010});

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.bcd_valid = ($urandom_range(0, 3) == 0);
            bus.bcd_in    = 8'($urandom);
            lz_blank      = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.bcd_valid = 1'b0;
        lz_blank      = 1'b0;
        settle();

        // Async reset mid-slot with a pending word
        wait_an(2'b10);
        send(8'h99);
        check_lit("pending full", {7'd0, bus.bcd_ready}, 8'h00);
        #2 rst = 1'b1;
        #1;
        check_lit("async an_n", {6'd0, an_n}, 8'h03);
        check_lit("async seg_n", {1'b0, seg_n}, 8'h7F);
        check_lit("async dp_n/ready", {6'd0, dp_n, bus.bcd_ready}, 8'h03);
        @(negedge clk);
        rst = 1'b0;
        settle();
        wait_an(2'b10);
        check_lit("post rst d0", {1'b0, seg_n}, {1'b0, 7'b1000000});
        wait_an(2'b01);
        check_lit("post rst d1", {1'b0, seg_n}, {1'b0, 7'b1000000});

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_bcd_7seg_scan
`default_nettype wire
